// File: rtl/lsu_pkg.sv
// Shared state type, Funct3 size/sign encodings and access-legality helpers
// for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Offset of the lowest selected byte lane; misaligned half/word truncate to their boundary.
    function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return off;
            F3_H, F3_HU: return {off[1], 1'b0};
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if #(
    parameter int unsigned M = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [M-1:0] mem_addr;
    logic [3:0]   mem_be;
    logic [M-1:0] mem_wdata;
    logic [M-1:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation and store steering for the incoming
// access, plus lane extraction and sign/zero extension of the returned read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_offset_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_offset_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [1:0]  st_lane;
    logic [1:0]  ld_lane;
    logic [31:0] ld_shifted;

    always_comb begin
        st_lane   = lane_offset(st_funct3_i, st_offset_i);
        st_be_o   = 4'b0000;
        st_data_o = st_data_i;
        case (st_funct3_i)
            F3_B, F3_BU: begin
                st_be_o   = 4'b0001 << st_lane;
                st_data_o = {4{st_data_i[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be_o   = 4'b0011 << st_lane;
                st_data_o = {2{st_data_i[15:0]}};
            end
            F3_W:    st_be_o = 4'b1111;
            default: st_be_o = 4'b0000;
        endcase
    end

    always_comb begin
        ld_lane    = lane_offset(ld_funct3_i, ld_offset_i);
        ld_shifted = ld_word_i >> {ld_lane, 3'b000};
        ld_data_o  = '0;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data_o = {24'h000000, ld_shifted[7:0]};
            F3_H:    ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data_o = {16'h0000, ld_shifted[15:0]};
            F3_W:    ld_data_o = ld_word_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> DONE bus sequencer with lane steering and load extension.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of truncating.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned M = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M-1:0]      ALUResultM,
    input  logic [M-1:0]      WriteDataM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    load_store_unit_if.master mem,
    output logic [M-1:0]      ReadDataM,
    output logic              StallM,
    output logic              ErrM
);

    lsu_state_e  state_q, state_d;
    logic        req;
    logic        access, misaligned, accept, reject;
    logic [M-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_data;

    assign access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = f3_misaligned(Funct3M, ALUResultM[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = access & f3_legal(Funct3M) & ~misaligned;
    assign reject = access & ~accept;

    lsu_align u_align (
        .st_funct3_i (Funct3M),
        .st_offset_i (ALUResultM[1:0]),
        .st_data_i   (WriteDataM),
        .st_be_o     (st_be),
        .st_data_o   (st_data),
        .ld_funct3_i (f3_q),
        .ld_offset_i (off_q),
        .ld_word_i   (mem.mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        StallM  = 1'b0;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    StallM  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                StallM = 1'b1;
                req    = 1'b1;
                if (mem.mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && reject;
            if (state_q == IDLE && accept) begin
                addr_q  <= {ALUResultM[M-1:2], 2'b00};
                wdata_q <= st_data;
                be_q    <= st_be;
                we_q    <= MemWriteM;
                f3_q    <= Funct3M;
                off_q   <= ALUResultM[1:0];
            end
            // A completed store leaves no load result behind.
            if (state_q == REQ && mem.mem_ready) begin
                rdata_q <= we_q ? '0 : ld_data;
            end
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
    assign ReadDataM     = rdata_q;
    assign ErrM          = err_q;

endmodule
